serial_parity_rx: RTL and testbench

//  Receive end of the team's XOR-parity serial link: deserialises an async-style frame
//  (start, DATA_W data bits LSB first, parity, stop) and checks parity with a running XOR.

---
 rtl/serial_parity_rx_if.sv | 44 ++++
 rtl/serial_parity_rx.sv | 197 +++++++++++++++++++
 tb/tb_serial_parity_rx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_rx_if
// Purpose  : Bundle of the serial receiver's line input and word-side outputs.
//            The receiver attaches through the master modport. The consumer
//            (I/O register file or test harness) attaches through the slave
//            modport.
// Signals  : rx_serial  - serial line, idle high, asynchronous to clk
//            data_out   - last received data word (DATA_W bits)
//            data_valid - one-cycle pulse when the word-side outputs update
//            parity_err - parity mismatch on the last frame
//            frame_err  - stop bit sampled low on the last frame
//            busy       - receiver is inside a frame
// Revision : 1.0 - initial release
// ============================================================================
interface serial_parity_rx_if #(
  parameter int DATA_W = 8
);
  logic              rx_serial;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    input  rx_serial,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output rx_serial,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_rx
// Purpose  : Receive end of the XOR-parity serial link. It deserialises a
//            frame made of a start bit, DATA_W data bits (LSB first), a parity
//            bit and a stop bit. Parity is checked with a running XOR.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous, active-high reset
//            bus  - serial_parity_rx_if.master. It carries rx_serial in, and
//                   data_out / data_valid / parity_err / frame_err / busy out.
// Params   : DATA_W (1..16), CLKS_PER_BIT (>=4, even), ODD_PARITY (0/1)
// Revision : 1.0 - initial release
// ============================================================================
module serial_parity_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ODD_PARITY   = 0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  serial_parity_rx_if.master bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] C_LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic             C_ODD       = 1'(ODD_PARITY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Two-flop synchroniser. It resets to the idle (high) line level so that
  // reset release is never seen as a start bit.
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx_serial;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // Frame state and datapath registers
  state_t            r_state,    w_state_next;
  logic [CNT_W-1:0]  r_cnt,      w_cnt_next;
  logic [BIT_W-1:0]  r_bit,      w_bit_next;
  logic [DATA_W-1:0] r_shift,    w_shift_next;
  logic              r_par,      w_par_next;
  logic              r_perr,     w_perr_next;
  logic              r_armed,    w_armed_next;
  logic [DATA_W-1:0] r_data_out, w_data_out_next;
  logic              r_perr_out, w_perr_out_next;
  logic              r_ferr_out, w_ferr_out_next;
  logic              r_valid,    w_valid_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
      r_armed    <= 1'b1;
      r_data_out <= '0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_bit      <= w_bit_next;
      r_shift    <= w_shift_next;
      r_par      <= w_par_next;
      r_perr     <= w_perr_next;
      r_armed    <= w_armed_next;
      r_data_out <= w_data_out_next;
      r_perr_out <= w_perr_out_next;
      r_ferr_out <= w_ferr_out_next;
      r_valid    <= w_valid_next;
    end
  end

  // The counter wraps to 0 at every sample point. The first sample lands in
  // the middle of the start bit. Each later sample is one full bit period
  // after the previous one, so it also lands in the middle of its bit.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_bit_next      = r_bit;
    w_shift_next    = r_shift;
    w_par_next      = r_par;
    w_perr_next     = r_perr;
    w_armed_next    = r_armed;
    w_data_out_next = r_data_out;
    w_perr_out_next = r_perr_out;
    w_ferr_out_next = r_ferr_out;
    w_valid_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (!r_armed) begin
          // After a break, wait for the line to return high before
          // accepting a new start bit.
          if (w_rx_s) begin
            w_armed_next = 1'b1;
          end
        end else if (!w_rx_s) begin
          w_state_next = S_START;
          w_bit_next   = '0;
          w_par_next   = 1'b0;
        end
      end

      S_START: begin
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_next = '0;
          // A high line at mid start bit is a glitch. Drop it silently.
          w_state_next = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (r_cnt == C_FULL_LAST) begin
          w_cnt_next          = '0;
          w_shift_next[r_bit] = w_rx_s;
          w_par_next          = r_par ^ w_rx_s;
          if (r_bit == C_LAST_BIT) begin
            w_state_next = S_PARITY;
          end else begin
            w_bit_next = r_bit + BIT_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (r_cnt == C_FULL_LAST) begin
          w_cnt_next   = '0;
          w_perr_next  = r_par ^ w_rx_s ^ C_ODD;
          w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (r_cnt == C_FULL_LAST) begin
          // Results register on the stop sample edge and become visible in
          // the following cycle. IDLE is re-entered mid stop bit, which lets
          // a back-to-back start bit be caught.
          w_cnt_next      = '0;
          w_data_out_next = r_shift;
          w_perr_out_next = r_perr;
          w_ferr_out_next = ~w_rx_s;
          w_valid_next    = 1'b1;
          w_armed_next    = w_rx_s;
          w_state_next    = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_valid;
  assign bus.parity_err = r_perr_out;
  assign bus.frame_err  = r_ferr_out;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_parity_rx
// Purpose  : Self-checking bench for serial_parity_rx. An even-parity and an
//            odd-parity receiver share one serial line. The frame driver
//            pushes the expected word, flags and data_valid cycle into one
//            queue per receiver. A monitor for each receiver pops and compares
//            every data_valid it sees.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_parity_rx;

  localparam int DATA_W = 8;
  localparam int CPB    = 16;
  // Cycles from driving the start-bit edge to the data_valid cycle. The
  // total is 2 synchroniser stages + half a bit + (DATA_W+2) bits + 1.
  localparam int LAT    = 2 + CPB / 2 + (DATA_W + 2) * CPB + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q_e[$];
  exp_t q_o[$];
  exp_t e_e;
  exp_t e_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_parity_rx_if #(.DATA_W(DATA_W)) bus_e ();
  serial_parity_rx_if #(.DATA_W(DATA_W)) bus_o ();

  assign bus_e.rx_serial = rx_line;
  assign bus_o.rx_serial = rx_line;

  serial_parity_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut_even (
    .clk (clk),
    .rst (rst),
    .bus (bus_e)
  );

  serial_parity_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_odd (
    .clk (clk),
    .rst (rst),
    .bus (bus_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Each bit lasts exactly CPB cycles. Bits are driven on the falling edge.
  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s);
    exp_t x;
    x.data = d;
    x.ferr = ~s;
    x.due  = cyc + LAT;
    x.perr = (^d) ^ p;
    q_e.push_back(x);
    x.perr = (^d) ^ p ^ 1'b1;
    q_o.push_back(x);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  // Scoreboard monitors. Outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (bus_e.data_valid === 1'b1) begin
      if (q_e.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL even unexpected_valid: got data_valid=1 data_out=%0h, expected no pulse", bus_e.data_out);
      end else begin
        e_e = q_e.pop_front();
        check("even data_out",   32'(bus_e.data_out), 32'(e_e.data));
        check("even parity_err", 32'(bus_e.parity_err), 32'(e_e.perr));
        check("even frame_err",  32'(bus_e.frame_err), 32'(e_e.ferr));
        check("even valid_cycle", 32'(cyc), 32'(e_e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (bus_o.data_valid === 1'b1) begin
      if (q_o.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL odd unexpected_valid: got data_valid=1 data_out=%0h, expected no pulse", bus_o.data_out);
      end else begin
        e_o = q_o.pop_front();
        check("odd data_out",   32'(bus_o.data_out), 32'(e_o.data));
        check("odd parity_err", 32'(bus_o.parity_err), 32'(e_o.perr));
        check("odd frame_err",  32'(bus_o.frame_err), 32'(e_o.ferr));
        check("odd valid_cycle", 32'(cyc), 32'(e_o.due));
      end
    end
  end

  initial begin
    int k;
    // Reset
    repeat (3) @(negedge clk);
    check("reset data_out",   32'(bus_e.data_out), 32'h0);
    check("reset data_valid", 32'(bus_e.data_valid), 32'h0);
    check("reset parity_err", 32'(bus_e.parity_err), 32'h0);
    check("reset frame_err",  32'(bus_e.frame_err), 32'h0);
    check("reset busy",       32'(bus_e.busy), 32'h0);
    check("reset odd busy",   32'(bus_o.busy), 32'h0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // 1: clean 0xA5 (even parity bit 0)
    send_frame(8'hA5, 1'b0, 1'b1);
    check("t1 busy_after", 32'(bus_e.busy), 32'h0);
    drive_bit(1'b1);

    // 2: 0x01 with parity bit 0. The even receiver flags an error and the odd one does not.
    send_frame(8'h01, 1'b0, 1'b1);
    drive_bit(1'b1);

    // 3: break. The stop bit is low and the line is held low for 40 bits.
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_line = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    check("t3 busy_in_break", 32'(bus_e.busy), 32'h0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    drive_bit(1'b1);

    // 4: a 4-clock glitch must not produce a frame
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    rx_line = 1'b1;
    check("t4 busy_rise", 32'(bus_e.busy), 32'h1);
    k = 0;
    while (bus_e.busy === 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("t4 busy_fall", 32'(bus_e.busy), 32'h0);
    drive_bit(1'b1);
    drive_bit(1'b1);

    // 5: reset in the middle of the data bits of 0xF0
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    #1 rst = 1'b1;
    #1;
    check("t5 rst data_out",   32'(bus_e.data_out), 32'h0);
    check("t5 rst data_valid", 32'(bus_e.data_valid), 32'h0);
    check("t5 rst parity_err", 32'(bus_e.parity_err), 32'h0);
    check("t5 rst frame_err",  32'(bus_e.frame_err), 32'h0);
    check("t5 rst busy",       32'(bus_e.busy), 32'h0);
    check("t5 rst odd data_out", 32'(bus_o.data_out), 32'h0);
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    drive_bit(1'b1);

    // 6: back-to-back frames with no idle gap
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    drive_bit(1'b1);

    // Every issued frame must have been observed
    check("drain even queue", 32'(q_e.size()), 32'h0);
    check("drain odd queue",  32'(q_o.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
